multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/ctrl_decode.sv | 45 ++++
 rtl/multicycle_control_unit.sv | 135 +++++++++++++
 tb/tb_multicycle_control_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU operations,
// FSM states and the decoded-control bundle passed from ctrl_decode to the top.
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SLL = 2'b01;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } stateT;

  // Everything the FSM needs to know about the captured opcode
  typedef struct packed {
    logic       legal;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       isLoad;
    logic       isStore;
  } ctrlT;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder; the FSM gates these fields by state.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] opcode,
  output ctrlT            ctrl
);

  // Undefined opcodes fall through with legal=0 and every control cleared
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_W'(OP_ADD): begin
        ctrl.legal = 1'b1;
        ctrl.aluOp = ALUOP_ADD;
      end
      OP_W'(OP_ADDI): begin
        ctrl.legal  = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.aluOp  = ALUOP_ADD;
      end
      OP_W'(OP_SW): begin
        ctrl.legal   = 1'b1;
        ctrl.aluSrc  = 1'b1;
        ctrl.aluOp   = ALUOP_ADD;
        ctrl.isStore = 1'b1;
      end
      OP_W'(OP_LW): begin
        ctrl.legal  = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.aluOp  = ALUOP_ADD;
        ctrl.isLoad = 1'b1;
      end
      OP_W'(OP_SLL): begin
        ctrl.legal  = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.aluOp  = ALUOP_SLL;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Five-state multicycle CPU controller: FETCH, DECODE, EXEC, MEM, WB, with a
// bounded memory wait that aborts to FETCH on timeout.
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_W     = 8,
  parameter int OP_W        = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               RegWrite,
  output logic               ALUsrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic [1:0]         ALUop,
  output logic               done,
  output logic               illegal,
  output logic               mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  stateT            state;
  stateT            stateNext;
  logic [OP_W-1:0]  opcode;
  logic [CNT_W-1:0] waitCnt;
  logic             postReset;
  logic             accept;
  logic             memTimeout;
  logic             unusedInstr;
  ctrlT             ctrl;

  ctrl_decode #(
    .OP_W(OP_W)
  ) uDecode (
    .opcode(opcode),
    .ctrl  (ctrl)
  );

  assign unusedInstr = ^instr;

  // The cycle right after reset is kept quiet, so no instruction is accepted then
  assign accept     = (state == FETCH) && instr_valid && !postReset;
  assign memTimeout = (waitCnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      opcode    <= '0;
      waitCnt   <= '0;
      postReset <= 1'b1;
    end else begin
      state     <= stateNext;
      postReset <= 1'b0;
      if (accept) begin
        opcode <= instr[INSTR_W-1 -: OP_W];
      end
      if (state == EXEC) begin
        waitCnt <= '0;
      end else if ((state == MEM) && !mem_ready && !memTimeout) begin
        waitCnt <= waitCnt + 1'b1;
      end
    end
  end

  // A ready in the threshold cycle wins over the timeout
  always_comb begin
    stateNext = state;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    RegWrite  = 1'b0;
    ALUsrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUop     = ALUOP_ADD;
    done      = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    if (!rst && !postReset) begin
      case (state)
        FETCH: begin
          if (accept) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            stateNext = DECODE;
          end
        end
        DECODE: begin
          if (ctrl.legal) begin
            stateNext = EXEC;
          end else begin
            illegal   = 1'b1;
            stateNext = FETCH;
          end
        end
        EXEC: begin
          ALUsrc    = ctrl.aluSrc;
          ALUop     = ctrl.aluOp;
          stateNext = (ctrl.isLoad || ctrl.isStore) ? MEM : WB;
        end
        MEM: begin
          MemRead  = ctrl.isLoad;
          MemWrite = ctrl.isStore;
          if (mem_ready) begin
            if (ctrl.isStore) begin
              done      = 1'b1;
              stateNext = FETCH;
            end else begin
              stateNext = WB;
            end
          end else if (memTimeout) begin
            mem_err   = 1'b1;
            stateNext = FETCH;
          end
        end
        WB: begin
          RegWrite  = 1'b1;
          MemToReg  = ctrl.isLoad;
          done      = 1'b1;
          stateNext = FETCH;
        end
        default: stateNext = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: an instruction-level model
// predicts every output each cycle, plus directed literal expectations.
module tb_multicycle_control_unit;

  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  instr;
  logic        instrValid;
  logic        memReady;
  logic        irWrite, pcWrite, regWrite, aluSrc, memRead, memWrite, memToReg;
  logic [1:0]  aluOp;
  logic        done, illegal, memErr;
  logic [11:0] outVec;

  int checks = 0;
  int errors = 0;

  // Model state: where the current instruction is, counted from its accept cycle
  int         cycle = 0;
  bit         mBusy = 1'b0;
  bit         mPostRst = 1'b0;
  bit         mLoadWb = 1'b0;
  int         mAge = 0;
  int         mWaits = 0;
  logic [2:0] mOp = 3'b000;
  logic [11:0] expVec;
  logic eIr, ePc, eRw, eAs, eMr, eMw, eMtr, eDn, eIl, eMe;
  logic [1:0] eAop;
  int expLat;

  // Tallies of what the DUT actually did
  int dutAcceptCycle = 0;
  int lastLatency = 0;
  int lastIllegalAge = 0;
  int dutDone = 0, dutIllegal = 0, dutMemErr = 0;
  int dutRegWrite = 0, dutMemRead = 0, dutMemWrite = 0, dutMemToReg = 0;
  int sDone, sIllegal, sMemErr, sRegWrite, sMemRead, sMemWrite, sMemToReg;

  multicycle_control_unit #(
    .INSTR_W    (8),
    .OP_W       (3),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instrValid),
    .mem_ready  (memReady),
    .ir_write   (irWrite),
    .pc_write   (pcWrite),
    .RegWrite   (regWrite),
    .ALUsrc     (aluSrc),
    .MemRead    (memRead),
    .MemWrite   (memWrite),
    .MemToReg   (memToReg),
    .ALUop      (aluOp),
    .done       (done),
    .illegal    (illegal),
    .mem_err    (memErr)
  );

  always #5 clk = ~clk;

  assign outVec = {irWrite, pcWrite, regWrite, aluSrc, memRead, memWrite,
                   memToReg, aluOp, done, illegal, memErr};

  function automatic bit isLegalOp(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b100) || (op == 3'b101) ||
           (op == 3'b110) || (op == 3'b111);
  endfunction

  function automatic bit isMemOp(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic takeSnapshot();
    sDone = dutDone; sIllegal = dutIllegal; sMemErr = dutMemErr;
    sRegWrite = dutRegWrite; sMemRead = dutMemRead;
    sMemWrite = dutMemWrite; sMemToReg = dutMemToReg;
  endtask

  // Per-cycle model and compare; inputs are stable here, set just after posedge
  always @(negedge clk) begin
    {eIr, ePc, eRw, eAs, eMr, eMw, eMtr, eDn, eIl, eMe} = '0;
    eAop = 2'b00;
    cycle++;
    if (rst || mPostRst) begin
      mBusy   = 1'b0;
      mLoadWb = 1'b0;
    end else if (!mBusy) begin
      if (instrValid) begin
        eIr = 1'b1; ePc = 1'b1;
        mBusy = 1'b1; mAge = 1; mOp = instr[7:5]; mWaits = 0; mLoadWb = 1'b0;
      end
    end else begin
      mAge++;
      if (mAge == 2) begin
        if (!isLegalOp(mOp)) begin
          eIl = 1'b1; mBusy = 1'b0;
        end
      end else if (mAge == 3) begin
        eAs  = (mOp != 3'b000);
        eAop = (mOp == 3'b111) ? 2'b01 : 2'b00;
      end else if (!isMemOp(mOp) || mLoadWb) begin
        eRw = 1'b1; eMtr = (mOp == 3'b110); eDn = 1'b1; mBusy = 1'b0;
      end else begin
        eMr = (mOp == 3'b110);
        eMw = (mOp == 3'b101);
        if (memReady) begin
          if (mOp == 3'b101) begin
            eDn = 1'b1; mBusy = 1'b0;
          end else begin
            mLoadWb = 1'b1;
          end
        end else if (mWaits == MEM_TIMEOUT) begin
          eMe = 1'b1; mBusy = 1'b0;
        end else begin
          mWaits++;
        end
      end
    end
    mPostRst = rst;
    expVec = {eIr, ePc, eRw, eAs, eMr, eMw, eMtr, eAop, eDn, eIl, eMe};
    checkOutput("outputs", 32'(outVec), 32'(expVec));

    if (irWrite === 1'b1) dutAcceptCycle = cycle;
    if (done === 1'b1) dutDone++;
    if (illegal === 1'b1) begin
      dutIllegal++;
      lastIllegalAge = cycle - dutAcceptCycle + 1;
    end
    if (memErr === 1'b1) dutMemErr++;
    if (regWrite === 1'b1) dutRegWrite++;
    if (memRead === 1'b1) dutMemRead++;
    if (memWrite === 1'b1) dutMemWrite++;
    if (memToReg === 1'b1) dutMemToReg++;
    if (done === 1'b1 && eDn) begin
      lastLatency = cycle - dutAcceptCycle + 1;
      expLat = !isMemOp(mOp) ? 4 : (mOp == 3'b101) ? 4 + mWaits : 5 + mWaits;
      checkOutput("latency", lastLatency, expLat);
    end
  end

  // One instruction from accept to retirement; waitCycles<0 means memory never
  // answers, rstAge>0 pulses rst in that cycle of the instruction
  task automatic applyStimulus(input logic [7:0] ins, input int waitCycles,
                               input int rstAge, input bit noise);
    logic [2:0] op;
    bit legal, memOp;
    int endAge;
    op    = ins[7:5];
    legal = isLegalOp(op);
    memOp = legal && isMemOp(op);
    if (!legal) endAge = 2;
    else if (!memOp) endAge = 4;
    else if (waitCycles < 0) endAge = 4 + MEM_TIMEOUT;
    else endAge = (op == 3'b110) ? 5 + waitCycles : 4 + waitCycles;
    if (rstAge > 0 && rstAge <= endAge) endAge = rstAge;
    else rstAge = 0;

    instr = ins; instrValid = 1'b1; rst = 1'b0;
    memReady = noise ? 1'($urandom) : 1'b0;
    for (int age = 2; age <= endAge; age++) begin
      @(posedge clk); #1;
      instr      = noise ? 8'($urandom) : 8'h00;
      instrValid = noise ? 1'($urandom) : 1'b0;
      if (memOp && age >= 4) memReady = (waitCycles >= 0) && (age >= 4 + waitCycles);
      else memReady = noise ? 1'($urandom) : 1'b0;
      rst = (age == rstAge);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    if (rstAge > 0) begin
      instrValid = 1'b1;
      instr      = 8'h05;
      @(posedge clk); #1;
    end
    instrValid = 1'b0;
    memReady   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      instrValid = 1'b0;
      instr      = 8'($urandom);
      memReady   = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int w, rAge;
    logic [7:0] ins;
    rst = 1'b1; instrValid = 1'b0; instr = 8'h00; memReady = 1'b0;
    $display("[TB] starting multicycle_control_unit bench");

    @(negedge clk);
    checkOutput("reset cycle outputs", 32'(outVec), 0);
    @(posedge clk); #1;
    rst = 1'b0; instrValid = 1'b1; instr = 8'h05;
    @(negedge clk);
    checkOutput("post-reset outputs", 32'(outVec), 0);
    @(posedge clk); #1;
    instrValid = 1'b0;

    takeSnapshot();
    applyStimulus(8'h05, 0, 0, 1'b0);
    checkOutput("add done count", dutDone - sDone, 1);
    checkOutput("add latency", lastLatency, 4);
    checkOutput("add regwrite count", dutRegWrite - sRegWrite, 1);
    checkOutput("add memtoreg count", dutMemToReg - sMemToReg, 0);

    takeSnapshot();
    applyStimulus(8'hC3, 2, 0, 1'b0);
    checkOutput("lw done count", dutDone - sDone, 1);
    checkOutput("lw latency", lastLatency, 7);
    checkOutput("lw memread count", dutMemRead - sMemRead, 3);
    checkOutput("lw memtoreg count", dutMemToReg - sMemToReg, 1);
    checkOutput("lw regwrite count", dutRegWrite - sRegWrite, 1);

    takeSnapshot();
    applyStimulus(8'hA1, 0, 0, 1'b0);
    checkOutput("sw memwrite count", dutMemWrite - sMemWrite, 1);
    checkOutput("sw done count", dutDone - sDone, 1);
    checkOutput("sw regwrite count", dutRegWrite - sRegWrite, 0);
    checkOutput("sw latency", lastLatency, 4);

    takeSnapshot();
    applyStimulus(8'h20, 0, 0, 1'b0);
    checkOutput("illegal count", dutIllegal - sIllegal, 1);
    checkOutput("illegal age", lastIllegalAge, 2);
    checkOutput("illegal regwrite count", dutRegWrite - sRegWrite, 0);
    checkOutput("illegal memwrite count", dutMemWrite - sMemWrite, 0);

    takeSnapshot();
    applyStimulus(8'hC3, -1, 0, 1'b0);
    checkOutput("timeout memerr count", dutMemErr - sMemErr, 1);
    checkOutput("timeout regwrite count", dutRegWrite - sRegWrite, 0);
    checkOutput("timeout done count", dutDone - sDone, 0);
    takeSnapshot();
    applyStimulus(8'h05, 0, 0, 1'b0);
    checkOutput("add after timeout done", dutDone - sDone, 1);
    checkOutput("add after timeout latency", lastLatency, 4);

    takeSnapshot();
    applyStimulus(8'hC0, MEM_TIMEOUT, 0, 1'b0);
    checkOutput("lw ready at threshold memerr", dutMemErr - sMemErr, 0);
    checkOutput("lw ready at threshold latency", lastLatency, 20);
    applyStimulus(8'hA0, MEM_TIMEOUT, 0, 1'b0);
    checkOutput("sw ready at threshold latency", lastLatency, 19);

    takeSnapshot();
    applyStimulus(8'hA1, 10, 6, 1'b0);
    checkOutput("reset in mem done count", dutDone - sDone, 0);
    checkOutput("reset in mem memerr count", dutMemErr - sMemErr, 0);
    checkOutput("reset in mem illegal count", dutIllegal - sIllegal, 0);
    applyStimulus(8'h05, 0, 0, 1'b0);
    checkOutput("add after reset latency", lastLatency, 4);

    for (int n = 0; n < 120; n++) begin
      ins = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       w = -1;
        1:       w = MEM_TIMEOUT;
        default: w = $urandom_range(0, 4);
      endcase
      rAge = ($urandom_range(0, 11) == 0) ? $urandom_range(2, 6) : 0;
      applyStimulus(ins, w, rAge, 1'b1);
      idleCycles($urandom_range(0, 2));
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
